// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter and its pick logic.
package wrr_arbiter_pkg;

    localparam int MAX_CLIENTS = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index width used for client ids: $clog2(n), but never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_CLIENTS-1:0] lowest_one_hot(input logic [MAX_CLIENTS-1:0] v);
        return v & (~v + MAX_CLIENTS'(1));
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest masked request, else lowest raw request.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0]           masked;
    logic [N-1:0]           src;
    logic [MAX_CLIENTS-1:0] src_ext;
    logic [MAX_CLIENTS-1:0] oh_ext;

    always_comb begin
        masked         = req_i & mask_i;
        src            = (|masked) ? masked : req_i;
        src_ext        = '0;
        src_ext[N-1:0] = src;
        oh_ext         = lowest_one_hot(src_ext);
        pick_o         = oh_ext[N-1:0];
        idx_o          = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (oh_ext[i]) idx_o = IW'(i);
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a grantee holds the port for up to weight beats.
// Optional per-client starvation flags are built when WRR_ARBITER_STARVE_EN is defined.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter  int CLIENTS      = 4,
    parameter  int WEIGHT_W     = 4,
    parameter  int STARVE_LIMIT = 64,
    localparam int IW           = idx_width(CLIENTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CLIENTS-1:0]          req,
    input  logic [CLIENTS*WEIGHT_W-1:0] weight,
    input  logic                        ack,
    output logic [CLIENTS-1:0]          gnt,
    output logic [IW-1:0]               gnt_id,
    output state_e                      state_dbg,
    output logic                        busy
`ifdef WRR_ARBITER_STARVE_EN
    ,
    output logic [CLIENTS-1:0]          starve
`endif
);

    // Handshake: req[i] is a level held while client i wants the port; one beat
    // transfers on every cycle where gnt[i] and ack are both high.

    state_e              state_q, state_d;
    logic [CLIENTS-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]       gnt_id_q, gnt_id_d;
    logic [CLIENTS-1:0]  mask_q, mask_d;
    logic [WEIGHT_W-1:0] budget_q, budget_d;
    logic                busy_q, busy_d;

    logic [CLIENTS-1:0]  rel_mask;
    logic [CLIENTS-1:0]  pick_mask;
    logic [CLIENTS-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                release_now;
    logic [WEIGHT_W-1:0] pick_weight;

    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            rel_mask[i] = (i > int'(gnt_id_q));
        end
        release_now = (state_q == GRANT) &&
                      ((ack && (budget_q == WEIGHT_W'(1))) || !req[gnt_id_q]);
        // On a release edge the successor is chosen with the post-release mask.
        pick_mask   = release_now ? rel_mask : mask_q;
        pick_weight = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
        if (pick_weight == '0) pick_weight = WEIGHT_W'(1);
    end

    rr_pick #(
        .N  (CLIENTS),
        .IW (IW)
    ) u_pick (
        .req_i  (req),
        .mask_i (pick_mask),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        mask_d   = mask_q;
        budget_d = budget_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_oh;
                    gnt_id_d = pick_idx;
                    budget_d = pick_weight;
                end
            end
            GRANT: begin
                if (release_now) begin
                    mask_d = rel_mask;
                    if (pick_any) begin
                        gnt_d    = pick_oh;
                        gnt_id_d = pick_idx;
                        budget_d = pick_weight;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        budget_d = '0;
                    end
                end else if (ack) begin
                    budget_d = budget_q - WEIGHT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                budget_d = '0;
            end
        endcase
        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            mask_q   <= '1;
            budget_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            mask_q   <= mask_d;
            budget_q <= budget_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

`ifdef WRR_ARBITER_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CLIENTS-1:0][CW-1:0] wait_q, wait_d;
    logic [CLIENTS-1:0]         starve_q, starve_d;

    // The flag tracks the updated counter so it is high exactly while count >= limit.
    always_comb begin
        wait_d   = '0;
        starve_d = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (req[i] && !gnt_q[i]) begin
                wait_d[i] = (wait_q[i] == {CW{1'b1}}) ? wait_q[i] : wait_q[i] + CW'(1);
            end
            starve_d[i] = (wait_d[i] >= CW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`endif

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: scenario tasks with an expected-grant queue.
module tb_wrr_arbiter;
    import wrr_arbiter_pkg::*;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [3:0]  req    = '0;
    logic [15:0] weight = '0;
    logic        ack    = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    state_e      state_dbg;
    logic        busy;
`ifdef WRR_ARBITER_STARVE_EN
    logic [3:0]  starve;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    wrr_arbiter #(
        .CLIENTS      (4),
        .WEIGHT_W     (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .weight    (weight),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .state_dbg (state_dbg),
        .busy      (busy)
`ifdef WRR_ARBITER_STARVE_EN
        ,
        .starve    (starve)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] id_of(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic apply_reset();
        req   = '0;
        ack   = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_n  = 1'b0;
        req    = 4'b1111;
        ack    = 1'b1;
        weight = {4'd2, 4'd2, 4'd2, 4'd2};
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
        checks++;
        if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", state_dbg); end
        req   = '0;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) exp_q.push_back(4'b0000);
        repeat (3) exp_q.push_back(4'b0100);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== (exp != 4'b0) || (exp != 4'b0 && gnt_id !== id_of(exp))) begin
                failures++;
                $display("FAIL idle_ack cyc=%0d gnt=%b id=%0d busy=%b exp_gnt=%b", c, gnt, gnt_id, busy, exp);
            end
            if (c == 3) req = 4'b0100;
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req    = 4'b1111;
        ack    = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(4'b0001 << (i % 4));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL rotate cyc=%0d gnt=%b id=%0d busy=%b exp_gnt=%b", c, gnt, gnt_id, busy, exp);
            end
        end
    endtask

    task automatic test_weighted();
        logic [3:0] exp;
        logic [1:0] seq [7];
        seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        apply_reset();
        weight = {4'd1, 4'd2, 4'd1, 4'd3};
        req    = 4'b1111;
        ack    = 1'b1;
        for (int i = 0; i < 14; i++) exp_q.push_back(4'b0001 << seq[i % 7]);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL weighted cyc=%0d gnt=%b id=%0d exp_gnt=%b", c, gnt, gnt_id, exp);
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] exp;
        // Client 2 (weight 5) drops after two beats; client 3 is next in rotation.
        apply_reset();
        weight = {4'd1, 4'd5, 4'd1, 4'd1};
        req    = 4'b1100;
        ack    = 1'b1;
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0100); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b1000);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL drop_next cyc=%0d gnt=%b id=%0d exp_gnt=%b", c, gnt, gnt_id, exp);
            end
            if (c == 3) req = 4'b1000;
        end
        // Same drop with only client 0 left: the pick wraps around to it.
        apply_reset();
        weight = {4'd1, 4'd5, 4'd1, 4'd1};
        req    = 4'b0100;
        ack    = 1'b1;
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0100); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL drop_wrap cyc=%0d gnt=%b id=%0d exp_gnt=%b", c, gnt, gnt_id, exp);
            end
            if (c == 1) req = 4'b0101;
            if (c == 3) req = 4'b0001;
        end
    endtask

    task automatic test_sole();
        logic [3:0] exp;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd2, 4'd1};
        req    = 4'b0010;
        ack    = 1'b1;
        repeat (8) exp_q.push_back(4'b0010);
        repeat (2) exp_q.push_back(4'b0000);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== (exp != 4'b0) || (exp != 4'b0 && gnt_id !== id_of(exp))) begin
                failures++;
                $display("FAIL sole cyc=%0d gnt=%b id=%0d busy=%b exp_gnt=%b", c, gnt, gnt_id, busy, exp);
            end
            if (c == 8) req = 4'b0000;
        end
    endtask

    task automatic test_hold_reset();
        logic [3:0] exp;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        req    = 4'b0011;
        ack    = 1'b0;
        repeat (10) exp_q.push_back(4'b0001);
        // Budget of 3 must survive the stall: two more samples of client 0, then client 1.
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL hold cyc=%0d gnt=%b id=%0d exp_gnt=%b", c, gnt, gnt_id, exp);
            end
            if (c == 10) ack = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL async_reset gnt=%b busy=%b state=%0d exp gnt=0000 busy=0 IDLE", gnt, busy, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        exp_q.push_back(4'b1000); exp_q.push_back(4'b1000);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || busy !== 1'b1 || gnt_id !== id_of(exp)) begin
                failures++;
                $display("FAIL post_reset cyc=%0d gnt=%b id=%0d exp_gnt=%b", c, gnt, gnt_id, exp);
            end
        end
    endtask

`ifdef WRR_ARBITER_STARVE_EN
    task automatic test_starve();
        logic [3:0] exp;
        logic [3:0] exp_st;
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd15};
        req    = 4'b0011;
        ack    = 1'b0;
        repeat (10) exp_q.push_back(4'b0001);
        repeat (2) exp_q.push_back(4'b0010);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp    = exp_q.pop_front();
            exp_st = (c >= 8 && c <= 11) ? 4'b0010 : 4'b0000;
            checks++;
            if (gnt !== exp || starve !== exp_st) begin
                failures++;
                $display("FAIL starve cyc=%0d gnt=%b starve=%b exp_gnt=%b exp_starve=%b", c, gnt, starve, exp, exp_st);
            end
            if (c == 10) req = 4'b0010;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotate();
        test_weighted();
        test_drop();
        test_sole();
        test_hold_reset();
`ifdef WRR_ARBITER_STARVE_EN
        test_starve();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter with grant hold: N requesters share one downstream port; a granted client keeps the port for up to a per-client number of accepted beats (ack) or until it drops its request, then priority rotates past it. Successor of the single-cycle round-robin arbiter for multi-beat bus and DMA paths where clients need unequal bandwidth. It sits between client request logic and a shared master port.

## Interface
- CLIENTS, 4: number of requesters, ≥2
- WEIGHT_W, 4: width of each per-client weight (max beats per grant)
- STARVE_LIMIT, 64: wait-cycle threshold, used only with WRR_ARBITER_STARVE_EN
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  CLIENTS  per-client request level
- weight  in  CLIENTS*WEIGHT_W  packed weights, client i at [i*WEIGHT_W +: WEIGHT_W]
- ack  in  1  downstream accepted one beat from the current grantee
- gnt  out  CLIENTS  registered one-hot grant, all-zero when idle
- gnt_id  out  $clog2(CLIENTS)  index of the current grantee, valid when busy
- busy  out  1  a grant is active (equals |gnt)
- starve  out  CLIENTS  per-client starvation flag (only with WRR_ARBITER_STARVE_EN)

## Operation
- States: IDLE (no grant), GRANT (one client owns the port). State held in flops.
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, mask=all ones, budget=0, starve=0.
- Pick function: masked_req = req & mask. Grant the lowest set index of masked_req. If masked_req is zero, grant the lowest set index of req (wrap-around).
- IDLE: if |req, go to GRANT with the picked client and load budget = weight[pick]. A weight of 0 is treated as 1. The weight is sampled only at grant time; later changes do not affect the active grant.
- GRANT: each cycle with ack=1 decrements budget. Release happens when (ack && budget==1) or req[gnt_id]==0. If ack and a request drop occur in the same cycle, the beat is counted and the grant is released.
- On release: mask = '1 << (gnt_id+1). For gnt_id = CLIENTS-1 this gives mask=0, which forces the raw wrap-around. The next grant is picked at the same edge from current req with the new mask. If nothing is requested, go to IDLE.
- A sole remaining requester is regranted with a fresh budget through the raw fallback.
- ack in IDLE is ignored. Only one grant is active at any time; gnt is always one-hot or zero.

## Timing
- req rise in IDLE at cycle N: gnt is asserted from cycle N+1.
- Back-to-back handover: no bubble. A release edge loads the next grantee directly.
- A grant of weight W with ack held high lasts exactly W cycles.
- gnt, gnt_id and busy are pure flop outputs; there is no combinational path from req or ack.
- Reset mid-grant: gnt drops immediately (asynchronously), and the mask returns to all ones.

## Configuration
- WRR_ARBITER_STARVE_EN defined:
  - Adds per-client wait counters, each $clog2(STARVE_LIMIT+1) bits, saturating.
  - A counter increments each cycle its client has req=1 and gnt=0, and clears when the client is granted or drops req.
  - starve[i] is a registered flag, high while counter_i ≥ STARVE_LIMIT.
  - The flag is report-only and does not alter arbitration.
- WRR_ARBITER_STARVE_EN undefined: no counters, and no starve port.

## Structure
- Package wrr_arbiter_pkg holds:
  - the state enum (IDLE, GRANT)
  - the helper function for lowest-set-bit one-hot
  - the localparam convention for the index width
- One sub-module, rr_pick: purely combinational. Inputs are req and mask; outputs are the one-hot pick, its index and an any-flag. It is reusable by other arbiters.

## Test plan
- Reset, then CLIENTS=4, req=4'b1111, all weights 1, ack=1 constantly -> grants rotate 0,1,2,3,0 on consecutive cycles with no idle cycles.
- weights {3,1,2,1} for clients 0..3, all requesting, ack=1 -> gnt_id sequence 0,0,0,1,2,2,3, repeating.
- Client 2 granted with weight 5, drops req after 2 acks -> release on that edge, next grant goes to client 3 if it requests, otherwise wraps to the lowest requester.
- Only client 1 requests, weight 2, ack=1 -> gnt stays 4'b0010 continuously (regranted via wrap), with budget reloaded every 2 beats.
- Grant active with ack=0 for 10 cycles -> gnt is held and the budget is unchanged. Then assert rst_n=0 mid-grant -> gnt=0 at once; after release, req=4'b1000 is granted to client 3.
- WRR_ARBITER_STARVE_EN, STARVE_LIMIT=8, client 0 holds weight 15 with ack=0 while client 1 requests -> starve[1] rises after 8 waiting cycles and clears when client 1 is granted.
